multi_interval_timer: RTL

MULTI_INTERVAL_TIMER -- requirements
Module: multi_interval_timer

---
 rtl/multi_interval_timer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_interval_timer.sv
// Multi-channel down-counting interval timer behind a single-cycle OCP register port.
// Each channel has its own prescaler, periodic/one-shot mode and a maskable pending flag.
module multi_interval_timer #(
  parameter int unsigned NCHAN       = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BEN_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp,
  output logic                  o_intr,
  output logic [NCHAN-1:0]      o_intr_vec
);

  localparam logic [2:0] CmdIdle  = 3'd0;
  localparam logic [2:0] CmdWrite = 3'd1;
  localparam logic [2:0] CmdRead  = 3'd2;
  localparam logic [1:0] RespNull = 2'd0;
  localparam logic [1:0] RespDva  = 2'd1;
  localparam logic [1:0] RespErr  = 2'd3;

  logic [NCHAN-1:0]       en_q, en_d, reload_q, reload_d, imask_q, imask_d, pend_q, pend_d;
  logic [PRESC_WIDTH-1:0] presc_q [NCHAN];
  logic [PRESC_WIDTH-1:0] presc_d [NCHAN];
  logic [PRESC_WIDTH-1:0] pcnt_q  [NCHAN];
  logic [PRESC_WIDTH-1:0] pcnt_d  [NCHAN];
  logic [CNT_WIDTH-1:0]   cntr_q  [NCHAN];
  logic [CNT_WIDTH-1:0]   cntr_d  [NCHAN];
  logic [CNT_WIDTH-1:0]   curr_q  [NCHAN];
  logic [CNT_WIDTH-1:0]   curr_d  [NCHAN];
  logic [1:0]             resp_q, resp_d;
  logic [DATA_WIDTH-1:0]  sdata_q, sdata_d;
  logic                   intr_q;
  logic [NCHAN-1:0]       intr_vec_q;

  logic [7:0]            addr8;
  logic [2:0]            chan;
  logic [1:0]            reg_sel;
  logic                  is_rd, is_wr, is_pend, chan_ok, wr_ok;
  logic [NCHAN-1:0]      chan_sel;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] ctrl_word [NCHAN];
  logic [DATA_WIDTH-1:0] cntr_word [NCHAN];
  logic [DATA_WIDTH-1:0] curr_word [NCHAN];
  logic                  unused_addr;

  assign addr8       = i_MAddr[7:0];
  assign chan        = addr8[6:4];
  assign reg_sel     = addr8[3:2];
  assign unused_addr = ^{i_MAddr[ADDR_WIDTH-1:8], addr8[1:0]};
  assign is_rd       = (i_MCmd == CmdRead);
  assign is_wr       = (i_MCmd == CmdWrite);
  assign is_pend     = (addr8[7:2] == 6'h20);
  assign chan_ok     = !addr8[7] && (32'(chan) < NCHAN);
  // CURR is read-only; PEND is never reachable through chan_ok.
  assign wr_ok       = is_wr && chan_ok && (reg_sel != 2'd2);

  assign o_SCmdAccept = (i_MCmd != CmdIdle);
  assign o_SResp      = resp_q;
  assign o_SData      = sdata_q;
  assign o_intr       = intr_q;
  assign o_intr_vec   = intr_vec_q;

  always_comb begin
    chan_sel  = '0;
    lane_mask = '0;
    for (int i = 0; i < NCHAN; i++) begin
      chan_sel[i] = chan_ok && (32'(chan) == i);
    end
    for (int b = 0; b < BEN_WIDTH; b++) begin
      lane_mask[8*b +: 8] = {8{i_MByteEn[b]}};
    end
  end

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      ctrl_word[i]                     = '0;
      ctrl_word[i][0]                  = en_q[i];
      ctrl_word[i][1]                  = reload_q[i];
      ctrl_word[i][2]                  = imask_q[i];
      ctrl_word[i][8 +: PRESC_WIDTH]   = presc_q[i];
      cntr_word[i]                     = '0;
      cntr_word[i][CNT_WIDTH-1:0]      = cntr_q[i];
      curr_word[i]                     = '0;
      curr_word[i][CNT_WIDTH-1:0]      = curr_q[i];
    end
  end

  // Channel counting and register writes.
  always_comb begin
    logic                  ctrl_wr, cntr_wr, stat_wr, run, tick, expire;
    logic [DATA_WIDTH-1:0] wctrl, wcntr;
    en_d     = en_q;
    reload_d = reload_q;
    imask_d  = imask_q;
    pend_d   = pend_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    cntr_d   = cntr_q;
    curr_d   = curr_q;
    for (int i = 0; i < NCHAN; i++) begin
      ctrl_wr = wr_ok && chan_sel[i] && (reg_sel == 2'd0);
      cntr_wr = wr_ok && chan_sel[i] && (reg_sel == 2'd1);
      stat_wr = wr_ok && chan_sel[i] && (reg_sel == 2'd3);
      wctrl   = (ctrl_word[i] & ~lane_mask) | (i_MData & lane_mask);
      wcntr   = (cntr_word[i] & ~lane_mask) | (i_MData & lane_mask);
      // A disabling CTRL write freezes CURR and the prescaler in that same cycle.
      run     = en_q[i] && !(ctrl_wr && !wctrl[0]);
      tick    = run && (pcnt_q[i] == presc_q[i]);
      expire  = tick && (curr_q[i] == CNT_WIDTH'(1));

      if (run) begin
        pcnt_d[i] = tick ? '0 : pcnt_q[i] + PRESC_WIDTH'(1);
      end
      if (tick && (curr_q[i] != '0)) begin
        if (expire) begin
          if (reload_q[i]) begin
            curr_d[i] = cntr_q[i];
          end else begin
            curr_d[i] = '0;
            en_d[i]   = 1'b0;
          end
        end else begin
          curr_d[i] = curr_q[i] - CNT_WIDTH'(1);
        end
      end

      if (stat_wr && i_MByteEn[0] && i_MData[0]) begin
        pend_d[i] = 1'b0;
      end
      if (expire) begin
        pend_d[i] = 1'b1;
      end

      if (ctrl_wr) begin
        reload_d[i] = wctrl[1];
        imask_d[i]  = wctrl[2];
        presc_d[i]  = wctrl[8 +: PRESC_WIDTH];
        if (wctrl[0] && !en_q[i]) begin
          en_d[i]   = 1'b1;
          curr_d[i] = cntr_q[i];
          pcnt_d[i] = '0;
        end else begin
          // Keeping enable set cannot revive a one-shot that expires this cycle.
          en_d[i] = wctrl[0] & en_d[i];
        end
      end
      if (cntr_wr) begin
        cntr_d[i] = wcntr[CNT_WIDTH-1:0];
      end
    end
  end

  // Read mux and response generation.
  always_comb begin
    rdata = '0;
    if (is_pend) begin
      rdata[NCHAN-1:0] = pend_q;
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (chan_sel[i]) begin
        unique case (reg_sel)
          2'd0: rdata = ctrl_word[i];
          2'd1: rdata = cntr_word[i];
          2'd2: rdata = curr_word[i];
          2'd3: begin
            rdata    = '0;
            rdata[0] = pend_q[i];
          end
        endcase
      end
    end
    resp_d  = RespNull;
    sdata_d = '0;
    if (is_rd) begin
      if (is_pend || chan_ok) begin
        resp_d  = RespDva;
        sdata_d = rdata;
      end else begin
        resp_d = RespErr;
      end
    end else if (is_wr) begin
      resp_d = wr_ok ? RespDva : RespErr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= '0;
      reload_q   <= '0;
      imask_q    <= '0;
      pend_q     <= '0;
      resp_q     <= RespNull;
      sdata_q    <= '0;
      intr_q     <= 1'b0;
      intr_vec_q <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        presc_q[i] <= '0;
        pcnt_q[i]  <= '0;
        cntr_q[i]  <= '0;
        curr_q[i]  <= '0;
      end
    end else begin
      en_q       <= en_d;
      reload_q   <= reload_d;
      imask_q    <= imask_d;
      pend_q     <= pend_d;
      resp_q     <= resp_d;
      sdata_q    <= sdata_d;
      intr_q     <= |(pend_q & imask_q);
      intr_vec_q <= pend_q & imask_q;
      for (int i = 0; i < NCHAN; i++) begin
        presc_q[i] <= presc_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        cntr_q[i]  <= cntr_d[i];
        curr_q[i]  <= curr_d[i];
      end
    end
  end

endmodule
